// File: rtl/bit_sayma_birimi.sv
// Two-stage pipelined clz/ctz/cpop unit for the Zbb count instructions.
// S1 registers the prepared operand and half popcounts; S2 combines two 16-bit zero counters.

module zero_counter_16 (
  input  logic [15:0] veri,
  output logic [3:0]  sayi,
  output logic        tumu_sifir
);
  logic bulundu;

  always_comb begin
    sayi    = '0;
    bulundu = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!bulundu) begin
        if (veri[15 - i]) bulundu = 1'b1;
        else              sayi    = sayi + 4'd1;
      end
    end
  end

  assign tumu_sifir = ~|veri;
endmodule

module bit_sayma_birimi (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        islem_gecerli_i,
  output logic        islem_hazir_o,
  input  logic [1:0]  islem_kod_i,
  input  logic [31:0] islem_veri_i,
  input  logic        bosalt_i,
  output logic        sonuc_gecerli_o,
  input  logic        sonuc_hazir_i,
  output logic [31:0] sonuc_o
);
  typedef enum logic [1:0] {
    KOD_CLZ  = 2'b00,
    KOD_CTZ  = 2'b01,
    KOD_CPOP = 2'b10,
    KOD_RSV  = 2'b11
  } islem_kod_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  logic        s1_gecerli;
  islem_kod_t  s1_kod;
  logic [31:0] s1_veri;
  logic [4:0]  s1_pop_h, s1_pop_l;

  logic        s2_ilerle, s1_ilerle, kabul;
  islem_kod_t  gelen_kod;
  logic [31:0] ters_veri, hazir_veri;
  logic [3:0]  zh, zl;
  logic        vh, vl;
  logic [31:0] s2_sonuc;

  assign s2_ilerle     = ~sonuc_gecerli_o | sonuc_hazir_i;
  assign s1_ilerle     = s1_gecerli & s2_ilerle;
  assign islem_hazir_o = ~s1_gecerli | s2_ilerle;
  assign kabul         = islem_gecerli_i & islem_hazir_o & ~bosalt_i;
  assign gelen_kod     = islem_kod_t'(islem_kod_i);

  // ctz is turned into clz of the bit-reversed operand so S2 only needs leading-zero logic
  always_comb begin
    ters_veri = '0;
    for (int unsigned i = 0; i < 32; i++) ters_veri[i] = islem_veri_i[31 - i];
    hazir_veri = (gelen_kod == KOD_CTZ) ? ters_veri : islem_veri_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_gecerli      <= 1'b0;
      sonuc_gecerli_o <= 1'b0;
    end else if (bosalt_i) begin
      s1_gecerli      <= 1'b0;
      sonuc_gecerli_o <= 1'b0;
    end else begin
      if (islem_hazir_o) s1_gecerli      <= islem_gecerli_i;
      if (s2_ilerle)     sonuc_gecerli_o <= s1_gecerli;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_kod   <= KOD_CLZ;
      s1_veri  <= '0;
      s1_pop_h <= '0;
      s1_pop_l <= '0;
    end else if (kabul) begin
      s1_kod   <= gelen_kod;
      s1_veri  <= hazir_veri;
      s1_pop_h <= popcount16(islem_veri_i[31:16]);
      s1_pop_l <= popcount16(islem_veri_i[15:0]);
    end
  end

  zero_counter_16 u_h (.veri(s1_veri[31:16]), .sayi(zh), .tumu_sifir(vh));
  zero_counter_16 u_l (.veri(s1_veri[15:0]),  .sayi(zl), .tumu_sifir(vl));

  always_comb begin
    s2_sonuc = '0;
    unique case (s1_kod)
      KOD_CLZ, KOD_CTZ: begin
        if (!vh)      s2_sonuc = {28'd0, zh};
        else if (!vl) s2_sonuc = 32'd16 + {28'd0, zl};
        else          s2_sonuc = 32'd32;
      end
      KOD_CPOP: s2_sonuc = {26'd0, {1'b0, s1_pop_h} + {1'b0, s1_pop_l}};
      default:  s2_sonuc = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                     sonuc_o <= '0;
    else if (s1_ilerle && !bosalt_i) sonuc_o <= s2_sonuc;
  end
endmodule

// File: tb/tb_bit_sayma_birimi.sv
// Self-checking bench for bit_sayma_birimi: directed steps plus random regression with an in-order scoreboard.

module tb_bit_sayma_birimi;
  logic        clk = 1'b0;
  logic        rst_i;
  logic        islem_gecerli;
  logic        islem_hazir;
  logic [1:0]  islem_kod;
  logic [31:0] islem_veri;
  logic        bosalt;
  logic        sonuc_gecerli;
  logic        sonuc_hazir;
  logic [31:0] sonuc;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned kabul_sayisi = 0;
  logic [31:0] kuyruk[$];

  always #5 clk = ~clk;

  bit_sayma_birimi dut (
    .clk_i(clk), .rst_i(rst_i),
    .islem_gecerli_i(islem_gecerli), .islem_hazir_o(islem_hazir),
    .islem_kod_i(islem_kod), .islem_veri_i(islem_veri),
    .bosalt_i(bosalt),
    .sonuc_gecerli_o(sonuc_gecerli), .sonuc_hazir_i(sonuc_hazir),
    .sonuc_o(sonuc)
  );

  function automatic logic [31:0] ref_sonuc(input logic [1:0] kod, input logic [31:0] v);
    int n;
    bit dur;
    n = 0;
    dur = 0;
    case (kod)
      2'b00: for (int i = 31; i >= 0; i--) begin if (v[i]) dur = 1; if (!dur) n++; end
      2'b01: for (int i = 0; i < 32; i++)  begin if (v[i]) dur = 1; if (!dur) n++; end
      2'b10: for (int i = 0; i < 32; i++)  if (v[i]) n++;
      default: n = 0;
    endcase
    return 32'(n);
  endfunction

  task automatic kontrol(input string tag, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    checks++;
    assert (gozlenen === beklenen) else begin
      errors++;
      $error("FAIL %s gozlenen=%0h beklenen=%0h", tag, gozlenen, beklenen);
    end
  endtask

  // One clock: scoreboard at the falling edge, stall-stability check just after the rising edge.
  task automatic adim();
    logic        tut;
    logic [31:0] eski;
    @(negedge clk);
    if (rst_i && !bosalt && sonuc_gecerli && sonuc_hazir) begin
      kontrol("kuyruk_dolu", 32'(kuyruk.size() > 0), 32'd1);
      if (kuyruk.size() > 0) kontrol("sira_sonuc", sonuc, kuyruk.pop_front());
    end
    if (bosalt) kuyruk.delete();
    else if (rst_i && islem_gecerli && islem_hazir) begin
      kuyruk.push_back(ref_sonuc(islem_kod, islem_veri));
      kabul_sayisi++;
    end
    tut  = rst_i & sonuc_gecerli & ~sonuc_hazir & ~bosalt;
    eski = sonuc;
    @(posedge clk);
    #1;
    if (tut) begin
      kontrol("bekleme_sonuc", sonuc, eski);
      kontrol("bekleme_gecerli", 32'(sonuc_gecerli), 32'd1);
    end
  endtask

  task automatic tek(input string tag, input logic [1:0] kod, input logic [31:0] veri, input logic [31:0] bek);
    islem_gecerli = 1'b1; islem_kod = kod; islem_veri = veri; sonuc_hazir = 1'b1;
    adim();
    islem_gecerli = 1'b0;
    kontrol({tag, "_s1_gecerli"}, 32'(sonuc_gecerli), 32'd0);
    adim();
    kontrol({tag, "_gecerli"}, 32'(sonuc_gecerli), 32'd1);
    kontrol({tag, "_sonuc"}, sonuc, bek);
    adim();
    kontrol({tag, "_bosaldi"}, 32'(sonuc_gecerli), 32'd0);
  endtask

  initial begin
    logic [1:0]  kodlar[10];
    logic [31:0] veriler[10];
    logic [31:0] beklenen[10];
    int unsigned dongu;

    rst_i = 1'b0; islem_gecerli = 1'b0; islem_kod = 2'b00; islem_veri = '0;
    bosalt = 1'b0; sonuc_hazir = 1'b1;
    #3;
    kontrol("rst_gecerli", 32'(sonuc_gecerli), 32'd0);
    kontrol("rst_sonuc", sonuc, 32'd0);
    kontrol("rst_hazir", 32'(islem_hazir), 32'd1);
    @(posedge clk); #1;
    rst_i = 1'b1;

    kodlar   = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
    veriler  = '{32'h0001_0000, 32'h0001_0000, 32'hF0F0_000F, 32'h0, 32'h0, 32'h0,
                 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h0000_1234};
    beklenen = '{32'd15, 32'd16, 32'd12, 32'd32, 32'd32, 32'd0, 32'd32, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 10; i++) tek($sformatf("yon%0d", i), kodlar[i], veriler[i], beklenen[i]);

    // Back-to-back with output stall.
    islem_gecerli = 1'b1; islem_kod = 2'b00; islem_veri = 32'h00F0_0000; sonuc_hazir = 1'b1;
    adim();
    islem_kod = 2'b01; islem_veri = 32'h0000_0400; sonuc_hazir = 1'b0;
    adim();
    kontrol("dolu_hazir", 32'(islem_hazir), 32'd0);
    islem_kod = 2'b10; islem_veri = 32'h0F0F_0F0F;
    for (int i = 0; i < 3; i++) begin
      adim();
      kontrol("durdu_sonuc", sonuc, 32'd8);
      kontrol("durdu_hazir", 32'(islem_hazir), 32'd0);
    end
    sonuc_hazir = 1'b1;
    adim();
    kontrol("akis_b", sonuc, 32'd10);
    islem_kod = 2'b00; islem_veri = 32'h0000_0003;
    adim();
    kontrol("akis_c", sonuc, 32'd16);
    islem_gecerli = 1'b0;
    adim();
    kontrol("akis_d", sonuc, 32'd30);
    kontrol("akis_d_gecerli", 32'(sonuc_gecerli), 32'd1);
    adim();
    kontrol("akis_bitti", 32'(sonuc_gecerli), 32'd0);
    kontrol("akis_kuyruk", 32'(kuyruk.size()), 32'd0);

    // Flush with both stages full and a request in the same cycle.
    sonuc_hazir = 1'b0; islem_gecerli = 1'b1; islem_kod = 2'b00; islem_veri = 32'h1;
    adim();
    islem_veri = 32'h2;
    adim();
    bosalt = 1'b1; islem_veri = 32'h3;
    kontrol("bosalt_oncesi_hazir", 32'(islem_hazir), 32'd0);
    adim();
    bosalt = 1'b0; islem_gecerli = 1'b0;
    kontrol("bosalt_gecerli", 32'(sonuc_gecerli), 32'd0);
    kontrol("bosalt_hazir", 32'(islem_hazir), 32'd1);
    sonuc_hazir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adim();
      kontrol("bosalt_sonra", 32'(sonuc_gecerli), 32'd0);
    end

    // Asynchronous reset with both stages valid.
    sonuc_hazir = 1'b0; islem_gecerli = 1'b1; islem_kod = 2'b10; islem_veri = 32'hFFFF_0000;
    adim();
    adim();
    islem_gecerli = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    kontrol("arst_gecerli", 32'(sonuc_gecerli), 32'd0);
    kontrol("arst_sonuc", sonuc, 32'd0);
    kontrol("arst_hazir", 32'(islem_hazir), 32'd1);
    kuyruk.delete();
    adim();
    rst_i = 1'b1;
    tek("arst_sonra", 2'b00, 32'h0000_FFFF, 32'd16);

    // Random regression with back-pressure.
    kabul_sayisi = 0;
    dongu = 0;
    while (kabul_sayisi < 10000 && dongu < 60000) begin
      islem_gecerli = ($urandom_range(0, 3) != 0);
      islem_kod     = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0:       islem_veri = $urandom;
        1:       islem_veri = $urandom >> $urandom_range(0, 31);
        2:       islem_veri = $urandom << $urandom_range(0, 31);
        3:       islem_veri = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
        default: islem_veri = 32'h1 << $urandom_range(0, 31);
      endcase
      sonuc_hazir = ($urandom_range(0, 2) != 0);
      adim();
      dongu++;
    end
    kontrol("rastgele_adet", kabul_sayisi, 32'd10000);
    islem_gecerli = 1'b0; sonuc_hazir = 1'b1;
    for (int i = 0; i < 5; i++) adim();
    kontrol("son_kuyruk", 32'(kuyruk.size()), 32'd0);
    kontrol("son_gecerli", 32'(sonuc_gecerli), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit_sayma_birimi.md
# bit_sayma_birimi

Two-stage pipelined bit-counting unit for the RV32 Zbb count instructions `clz`, `ctz` and `cpop`, sitting in the X-instruction execute path directly upstream of the result write-back mux.

- It consumes the 4-bit count and all-zero flag of two `zero_counter_16` instances, one per 16-bit half of the operand.
- It adds operand preparation, half-word popcount, result combining, a valid/ready handshake with downstream stall, and flush.

## Interface
Parameters:
- None. The operand width is fixed at 32 bits.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `islem_gecerli_i`  in  1  request valid.
- `islem_hazir_o`  out  1  unit can accept a request this cycle.
- `islem_kod_i`  in  2  opcode: 00 = clz, 01 = ctz, 10 = cpop, 11 = reserved.
- `islem_veri_i`  in  32  operand (rs1).
- `bosalt_i`  in  1  flush; kills every in-flight operation.
- `sonuc_gecerli_o`  out  1  result valid.
- `sonuc_hazir_i`  in  1  downstream accepts the result.
- `sonuc_o`  out  32  result, zero-extended count (0..32).

## Operation
Stage S1 (capture), combinational into the S1 registers:
- For clz, register the operand as-is.
- For ctz, register the bit-reversed operand, so ctz becomes clz of the reversed value.
- For cpop, register the operand plus two 5-bit popcounts, one for bits [31:16] and one for [15:0].
- Register the opcode and set `s1_gecerli`.

Stage S2 (count), combinational from S1 into the output register:
- Upper half [31:16] feeds `zero_counter_16` instance H (outputs Zh, Vh). Lower half [15:0] feeds instance L (outputs Zl, Vl).
- clz/ctz result:
  - Vh = 0: result is Zh.
  - Vh = 1 and Vl = 0: result is 16 + Zl.
  - Both set: result is 32.
- cpop result: sum of the two 5-bit half counts, 6 bits, range 0..32.
- Opcode 11 result: 0. This is not an error.
- The result is zero-extended to 32 bits into `sonuc_o`, and `sonuc_gecerli_o` is set.

Handshake:
- `s2_ilerle = ~sonuc_gecerli_o | sonuc_hazir_i`
- `s1_ilerle = s1_gecerli & s2_ilerle`
- `islem_hazir_o = ~s1_gecerli | s2_ilerle` (combinational, no bubble on back-to-back traffic).
- A request is accepted when `islem_gecerli_i & islem_hazir_o`.
- S2 loads on `s1_ilerle`. If S2 is being drained and S1 is empty, `sonuc_gecerli_o` clears.
- A stalled S2 holds `sonuc_o` and `sonuc_gecerli_o` stable, and S1 holds its contents.

Flush:
- `bosalt_i` clears `s1_gecerli` and `sonuc_gecerli_o` at the next edge. This has priority over accept and advance.
- A request presented in the same cycle as `bosalt_i` is discarded.
- `islem_hazir_o` is unaffected by `bosalt_i` in that cycle.

Reset (`rst_i` low, asynchronous):
- `s1_gecerli` = 0, `sonuc_gecerli_o` = 0, `sonuc_o` = 0, S1 data = 0.
- Hence `islem_hazir_o` = 1 while in reset.
- Reset in mid-operation discards everything in flight. There are no residual valids after release.

## Timing
- Latency: request accepted at edge N gives `sonuc_gecerli_o` high after edge N+1.
- Throughput: one result per cycle when `sonuc_hazir_i` = 1.
- Capacity: 2 operations in flight (S1 + S2). With the output stalled, the third request sees `islem_hazir_o` = 0.
- No combinational path from `islem_veri_i` to `sonuc_o`.
- The only combinational input-to-output path is `sonuc_hazir_i` to `islem_hazir_o`.
- The S2 critical path is the 16-bit zero counter plus a 5-bit add/mux, and must close within one cycle.

## Test plan
- **clz/ctz/cpop on one operand:** clz 0x00010000 -> 15; ctz 0x00010000 -> 16; cpop 0xF0F0000F -> 12; each valid exactly 2 edges after accept.
- **Boundaries:** clz 0 -> 32; ctz 0 -> 32; cpop 0 -> 0; cpop 0xFFFFFFFF -> 32; clz 0x80000000 -> 0; ctz 0x00000001 -> 0; opcode 11 with 0x1234 -> 0.
- **Back-to-back with stall:**
  - Issue 4 requests on consecutive cycles with `sonuc_hazir_i` = 0 from cycle 2.
  - `islem_hazir_o` drops after the 2nd accept.
  - Results stay stable while stalled, then emerge in order, one per cycle, after `sonuc_hazir_i` = 1.
  - No loss or duplication.
- **Flush:**
  - With both stages full, assert `bosalt_i` for 1 cycle together with a new request.
  - Next cycle: `sonuc_gecerli_o` = 0 and `islem_hazir_o` = 1.
  - No result for any of the three operations.
- **Async reset mid-operation:**
  - Drop `rst_i` between edges with both stages valid.
  - Outputs clear immediately: `sonuc_gecerli_o` = 0, `sonuc_o` = 0, `islem_hazir_o` = 1.
  - After release, a clz 0x0000FFFF request returns 16 with normal latency.
- **Random regression:** 10k random operands and opcodes with random `sonuc_hazir_i` back-pressure, checked against a reference count model in order.
